// File: rtl/stack_ctrl_pkg.sv
// Shared encodings for the stack controller: op codes, write sources, FSM states.
package stack_ctrl_pkg;

   localparam logic [2:0] OP_NOP     = 3'b000;
   localparam logic [2:0] OP_PUSH    = 3'b001;
   localparam logic [2:0] OP_POP     = 3'b010;
   localparam logic [2:0] OP_BINOP   = 3'b011;
   localparam logic [2:0] OP_REPLACE = 3'b100;
   localparam logic [2:0] OP_CLEAR   = 3'b101;

   localparam logic [1:0] SRC_NONE = 2'b00;
   localparam logic [1:0] SRC_ALU  = 2'b01;
   localparam logic [1:0] SRC_DMEM = 2'b10;
   localparam logic [1:0] SRC_PC   = 2'b11;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WB   = 1'b1
   } state_t;

endpackage

// File: rtl/stack_src_mux.sv
// Selects the stack write source; SRC_NONE yields zero.
module stack_src_mux
   import stack_ctrl_pkg::*;
#(
   parameter int unsigned REG_BITS = 32
) (
   input  logic [1:0]          push_src,
   input  logic [REG_BITS-1:0] alu_result,
   input  logic [REG_BITS-1:0] dmem_rdata,
   input  logic [REG_BITS-1:0] pc_temp,
   output logic [REG_BITS-1:0] data
);

   // Source select
   always_comb begin
      data = '0;
      case (push_src)
         SRC_ALU:  data = alu_result;
         SRC_DMEM: data = dmem_rdata;
         SRC_PC:   data = pc_temp;
         default:  data = '0;
      endcase
   end

endmodule

// File: rtl/stack_controller.sv
// Stack pointer / depth owner and Stack_Memory sequencer. BINOP takes an
// accept cycle (operands visible on read1/read2) plus a write-back cycle.
module stack_controller
   import stack_ctrl_pkg::*;
#(
   parameter int unsigned REG_BITS   = 32,
   parameter int unsigned DEPTH      = 64,
   parameter int unsigned STACK_BASE = 0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         op_valid,
   output logic                         op_ready,
   input  logic [2:0]                   op_code,
   input  logic [1:0]                   push_src,
   input  logic [REG_BITS-1:0]          alu_result,
   input  logic [REG_BITS-1:0]          dmem_rdata,
   input  logic [REG_BITS-1:0]          pc_temp,
   output logic [31:0]                  stack_sp,
   output logic                         stack_write,
   output logic [REG_BITS-1:0]          stack_wdata,
   output logic [31:0]                  top_sp,
   output logic [$clog2(DEPTH+1)-1:0]   depth,
   output logic                         empty,
   output logic                         full,
   output logic                         op_done,
   output logic                         err_overflow,
   output logic                         err_underflow
);

   localparam int unsigned DW = $clog2(DEPTH+1);

   state_t              state, state_nxt;
   logic [DW-1:0]       depth_nxt;
   logic [REG_BITS-1:0] result_q, result_nxt;
   logic [REG_BITS-1:0] src_data;
   logic                done_nxt, ovf_nxt, unf_nxt;

   stack_src_mux #(.REG_BITS(REG_BITS)) u_src_mux (
      .push_src   (push_src),
      .alu_result (alu_result),
      .dmem_rdata (dmem_rdata),
      .pc_temp    (pc_temp),
      .data       (src_data)
   );

   // Architectural status derived from the depth register
   assign top_sp = 32'(STACK_BASE) + 32'(depth);
   assign empty  = (depth == '0);
   assign full   = (depth == DW'(DEPTH));

   // State, depth, latched result, completion pulse and sticky errors
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         depth         <= '0;
         result_q      <= '0;
         op_done       <= 1'b0;
         err_overflow  <= 1'b0;
         err_underflow <= 1'b0;
      end else begin
         state         <= state_nxt;
         depth         <= depth_nxt;
         result_q      <= result_nxt;
         op_done       <= done_nxt;
         err_overflow  <= ovf_nxt;
         err_underflow <= unf_nxt;
      end
   end

   // Next-state and memory-port decode; writes are suppressed while in reset
   always_comb begin
      state_nxt   = state;
      depth_nxt   = depth;
      result_nxt  = result_q;
      done_nxt    = 1'b0;
      ovf_nxt     = err_overflow;
      unf_nxt     = err_underflow;
      op_ready    = 1'b0;
      stack_sp    = top_sp;
      stack_write = 1'b0;
      stack_wdata = src_data;

      if (state == ST_IDLE) begin
         op_ready = 1'b1;
         if (op_valid) begin
            done_nxt = 1'b1;
            case (op_code)
               OP_PUSH: begin
                  if (!full) begin
                     stack_sp    = top_sp + 32'd1;
                     stack_write = rst_n;
                     depth_nxt   = depth + DW'(1);
                  end else begin
                     ovf_nxt = 1'b1;
                  end
               end
               OP_POP: begin
                  if (!empty) depth_nxt = depth - DW'(1);
                  else        unf_nxt   = 1'b1;
               end
               OP_BINOP: begin
                  if (32'(depth) >= 32'd2) begin
                     result_nxt = alu_result;
                     state_nxt  = ST_WB;
                     done_nxt   = 1'b0;
                  end else begin
                     unf_nxt = 1'b1;
                  end
               end
               OP_REPLACE: begin
                  if (!empty) stack_write = rst_n;
                  else        unf_nxt     = 1'b1;
               end
               OP_CLEAR: begin
                  depth_nxt = '0;
                  ovf_nxt   = 1'b0;
                  unf_nxt   = 1'b0;
               end
               default: ;
            endcase
         end
      end else begin
         stack_sp    = top_sp - 32'd1;
         stack_write = rst_n;
         stack_wdata = result_q;
         depth_nxt   = depth - DW'(1);
         done_nxt    = 1'b1;
         state_nxt   = ST_IDLE;
      end
   end

endmodule

// File: tb/tb_stack_controller.sv
// Directed bench for stack_controller (DEPTH=4): vector table plus BINOP and reset-in-WB sequences.
module tb_stack_controller;
   import stack_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        op_valid;
   logic        op_ready;
   logic [2:0]  op_code;
   logic [1:0]  push_src;
   logic [31:0] alu_result, dmem_rdata, pc_temp;
   logic [31:0] stack_sp, stack_wdata, top_sp;
   logic        stack_write;
   logic [2:0]  depth;
   logic        empty, full, op_done, err_overflow, err_underflow;

   int checks = 0;
   int failures = 0;

   stack_controller #(.REG_BITS(32), .DEPTH(4), .STACK_BASE(0)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .op_valid      (op_valid),
      .op_ready      (op_ready),
      .op_code       (op_code),
      .push_src      (push_src),
      .alu_result    (alu_result),
      .dmem_rdata    (dmem_rdata),
      .pc_temp       (pc_temp),
      .stack_sp      (stack_sp),
      .stack_write   (stack_write),
      .stack_wdata   (stack_wdata),
      .top_sp        (top_sp),
      .depth         (depth),
      .empty         (empty),
      .full          (full),
      .op_done       (op_done),
      .err_overflow  (err_overflow),
      .err_underflow (err_underflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [2:0]  code;
      logic [1:0]  src;
      logic [31:0] data;
      logic [31:0] sp;
      logic        w;
      logic [31:0] wd;
      logic [2:0]  dep;
      logic        done;
      logic        ovf;
      logic        unf;
   } vec_t;

   vec_t tbl[22];

   function automatic vec_t mk(logic v, logic [2:0] code, logic [1:0] src, logic [31:0] data,
                               logic [31:0] sp, logic w, logic [31:0] wd,
                               logic [2:0] dep, logic done, logic ovf, logic unf);
      vec_t r;
      r.v = v; r.code = code; r.src = src; r.data = data; r.sp = sp; r.w = w; r.wd = wd;
      r.dep = dep; r.done = done; r.ovf = ovf; r.unf = unf;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Non-selected sources carry distinct filler so a wrong mux select is visible
   task automatic drive(input logic v, input logic [2:0] code, input logic [1:0] src, input logic [31:0] data);
      op_valid   = v;
      op_code    = code;
      push_src   = src;
      alu_result = (src == SRC_ALU)  ? data : 32'hAAAA_AAAA;
      dmem_rdata = (src == SRC_DMEM) ? data : 32'hBBBB_BBBB;
      pc_temp    = (src == SRC_PC)   ? data : 32'hCCCC_CCCC;
   endtask

   task automatic run_vec(input int i);
      vec_t t;
      t = tbl[i];
      drive(t.v, t.code, t.src, t.data);
      #1;
      chk($sformatf("v%0d op_ready", i), 32'(op_ready), 32'd1);
      chk($sformatf("v%0d stack_sp", i), stack_sp, t.sp);
      chk($sformatf("v%0d stack_write", i), 32'(stack_write), 32'(t.w));
      chk($sformatf("v%0d stack_wdata", i), stack_wdata, t.wd);
      @(posedge clk); #1;
      chk($sformatf("v%0d depth", i), 32'(depth), 32'(t.dep));
      chk($sformatf("v%0d top_sp", i), top_sp, 32'(t.dep));
      chk($sformatf("v%0d op_done", i), 32'(op_done), 32'(t.done));
      chk($sformatf("v%0d err_overflow", i), 32'(err_overflow), 32'(t.ovf));
      chk($sformatf("v%0d err_underflow", i), 32'(err_underflow), 32'(t.unf));
      chk($sformatf("v%0d empty", i), 32'(empty), 32'(t.dep == 3'd0));
      chk($sformatf("v%0d full", i), 32'(full), 32'(t.dep == 3'd4));
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, " depth"}, 32'(depth), 32'd0);
      chk({tag, " top_sp"}, top_sp, 32'd0);
      chk({tag, " op_ready"}, 32'(op_ready), 32'd1);
      chk({tag, " stack_sp"}, stack_sp, 32'd0);
      chk({tag, " stack_write"}, 32'(stack_write), 32'd0);
      chk({tag, " stack_wdata"}, stack_wdata, 32'd0);
      chk({tag, " op_done"}, 32'(op_done), 32'd0);
      chk({tag, " err_overflow"}, 32'(err_overflow), 32'd0);
      chk({tag, " err_underflow"}, 32'(err_underflow), 32'd0);
      chk({tag, " empty"}, 32'(empty), 32'd1);
   endtask

   initial begin
      //               v     code        src       data          sp  w  wd            dep d  ovf unf
      tbl[0]  = mk(1'b1, OP_PUSH,    SRC_ALU,  32'd7,        32'd1, 1, 32'd7,        3'd1, 1, 0, 0);
      tbl[1]  = mk(1'b1, OP_PUSH,    SRC_DMEM, 32'd4,        32'd2, 1, 32'd4,        3'd2, 1, 0, 0);
      tbl[2]  = mk(1'b0, OP_NOP,     SRC_NONE, 32'd0,        32'd2, 0, 32'd0,        3'd2, 0, 0, 0);
      tbl[3]  = mk(1'b1, OP_POP,     SRC_NONE, 32'd0,        32'd1, 0, 32'd0,        3'd0, 1, 0, 0);
      tbl[4]  = mk(1'b1, OP_POP,     SRC_NONE, 32'd0,        32'd0, 0, 32'd0,        3'd0, 1, 0, 1);
      tbl[5]  = mk(1'b1, OP_PUSH,    SRC_PC,   32'h40,       32'd1, 1, 32'h40,       3'd1, 1, 0, 1);
      tbl[6]  = mk(1'b1, OP_BINOP,   SRC_NONE, 32'd0,        32'd1, 0, 32'd0,        3'd1, 1, 0, 1);
      tbl[7]  = mk(1'b1, OP_CLEAR,   SRC_NONE, 32'd0,        32'd1, 0, 32'd0,        3'd0, 1, 0, 0);
      tbl[8]  = mk(1'b1, OP_PUSH,    SRC_PC,   32'h40,       32'd1, 1, 32'h40,       3'd1, 1, 0, 0);
      tbl[9]  = mk(1'b1, OP_PUSH,    SRC_PC,   32'h40,       32'd2, 1, 32'h40,       3'd2, 1, 0, 0);
      tbl[10] = mk(1'b1, OP_PUSH,    SRC_PC,   32'h40,       32'd3, 1, 32'h40,       3'd3, 1, 0, 0);
      tbl[11] = mk(1'b1, OP_PUSH,    SRC_PC,   32'h40,       32'd4, 1, 32'h40,       3'd4, 1, 0, 0);
      tbl[12] = mk(1'b1, OP_PUSH,    SRC_PC,   32'h40,       32'd4, 0, 32'h40,       3'd4, 1, 1, 0);
      tbl[13] = mk(1'b1, OP_POP,     SRC_NONE, 32'd0,        32'd4, 0, 32'd0,        3'd3, 1, 1, 0);
      tbl[14] = mk(1'b1, OP_REPLACE, SRC_ALU,  32'h55,       32'd3, 1, 32'h55,       3'd3, 1, 1, 0);
      tbl[15] = mk(1'b1, OP_NOP,     SRC_NONE, 32'd0,        32'd3, 0, 32'd0,        3'd3, 1, 1, 0);
      tbl[16] = mk(1'b1, 3'b111,     SRC_NONE, 32'd0,        32'd3, 0, 32'd0,        3'd3, 1, 1, 0);
      tbl[17] = mk(1'b1, OP_CLEAR,   SRC_NONE, 32'd0,        32'd3, 0, 32'd0,        3'd0, 1, 0, 0);
      tbl[18] = mk(1'b1, OP_REPLACE, SRC_ALU,  32'h55,       32'd0, 0, 32'h55,       3'd0, 1, 0, 1);
      tbl[19] = mk(1'b1, OP_CLEAR,   SRC_NONE, 32'd0,        32'd0, 0, 32'd0,        3'd0, 1, 0, 0);
      tbl[20] = mk(1'b1, OP_PUSH,    SRC_NONE, 32'd0,        32'd1, 1, 32'd0,        3'd1, 1, 0, 0);
      tbl[21] = mk(1'b1, OP_PUSH,    SRC_ALU,  32'd1,        32'd2, 1, 32'd1,        3'd2, 1, 0, 0);

      // Reset
      rst_n = 1'b0;
      drive(1'b0, OP_NOP, SRC_NONE, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      chk_reset_state("reset");
      rst_n = 1'b1;

      // Two pushes, then an idle cycle
      for (int i = 0; i <= 2; i++) run_vec(i);

      // BINOP at depth 2; op_valid held through WB with changed ALU input
      drive(1'b1, OP_BINOP, SRC_ALU, 32'd11);
      #1;
      chk("binop acc op_ready", 32'(op_ready), 32'd1);
      chk("binop acc stack_sp", stack_sp, 32'd2);
      chk("binop acc stack_write", 32'(stack_write), 32'd0);
      @(posedge clk); #1;
      drive(1'b1, OP_NOP, SRC_ALU, 32'd99);
      #1;
      chk("binop wb op_ready", 32'(op_ready), 32'd0);
      chk("binop wb stack_sp", stack_sp, 32'd1);
      chk("binop wb stack_write", 32'(stack_write), 32'd1);
      chk("binop wb stack_wdata", stack_wdata, 32'd11);
      chk("binop wb depth", 32'(depth), 32'd2);
      chk("binop wb op_done", 32'(op_done), 32'd0);
      @(posedge clk); #1;
      chk("binop ret depth", 32'(depth), 32'd1);
      chk("binop ret top_sp", top_sp, 32'd1);
      chk("binop ret op_done", 32'(op_done), 32'd1);
      chk("binop ret op_ready", 32'(op_ready), 32'd1);
      chk("binop ret stack_write", 32'(stack_write), 32'd0);
      @(posedge clk); #1;
      chk("held nop op_done", 32'(op_done), 32'd1);
      chk("held nop depth", 32'(depth), 32'd1);
      drive(1'b0, OP_NOP, SRC_NONE, 32'd0);

      // Pops, underflow, overflow, replace, illegal codes, clear
      for (int i = 3; i < 22; i++) run_vec(i);

      // BINOP accepted, reset asserted during WB
      drive(1'b1, OP_BINOP, SRC_ALU, 32'h77);
      @(posedge clk); #1;
      drive(1'b0, OP_NOP, SRC_NONE, 32'd0);
      rst_n = 1'b0;
      #1;
      chk("wb reset stack_write", 32'(stack_write), 32'd0);
      @(posedge clk); #1;
      chk_reset_state("wb reset");
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post reset depth", 32'(depth), 32'd0);
      chk("post reset op_done", 32'(op_done), 32'd0);
      chk("post reset stack_write", 32'(stack_write), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/stack_controller.md
Name: stack_controller

Overview:
- Sequences the shared Stack_Memory for the stack-machine datapath.
- Owns the architectural stack pointer and depth count, and generates the memory SP, StackWrite and write_data.
- Accepts one stack operation at a time over a valid/ready handshake and serialises two-cycle ops so the memory's single write port is never oversubscribed.
- Sits between the decode/control unit and Stack_Memory.

Parameters:
- REG_BITS, 32, data word width (matches Stack_Memory).
- DEPTH, 64, maximum number of stacked entries.
- STACK_BASE, 0, empty-stack SP value; entries occupy STACK_BASE+1 .. STACK_BASE+DEPTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- op_valid  in  1  operation request.
- op_ready  out  1  controller can accept an op this cycle.
- op_code  in  3  000 NOP, 001 PUSH, 010 POP, 011 BINOP, 100 REPLACE, 101 CLEAR; 110/111 treated as NOP.
- push_src  in  2  write source: 00 none, 01 alu_result, 10 dmem_rdata, 11 pc_temp.
- alu_result  in  REG_BITS  ALU output.
- dmem_rdata  in  REG_BITS  data memory read value.
- pc_temp  in  REG_BITS  return PC.
- stack_sp  out  32  drives Stack_Memory SP (read1=mem[SP], read2=mem[SP-1], write at SP).
- stack_write  out  1  drives Stack_Memory StackWrite.
- stack_wdata  out  REG_BITS  drives Stack_Memory write_data.
- top_sp  out  32  architectural top-of-stack address (STACK_BASE+depth).
- depth  out  $clog2(DEPTH+1)  current entry count.
- empty  out  1  depth==0.
- full  out  1  depth==DEPTH.
- op_done  out  1  one-cycle pulse, registered, the cycle after an op retires.
- err_overflow  out  1  sticky.
- err_underflow  out  1  sticky.

Behaviour:
- Reset (rst_n=0 at a clk edge) sets:
  - depth=0, top_sp=STACK_BASE, state IDLE;
  - stack_write=0, op_done=0, both error flags 0;
  - op_ready=1, stack_sp=STACK_BASE, stack_wdata=0.
- Reset mid-WB aborts the pending write; no write is issued.
- FSM states: IDLE, WB.
- IDLE:
  - op_ready=1.
  - Default stack_sp=top_sp, so read1=TOS and read2=NOS are continuously visible.
  - An op is accepted when op_valid && op_ready at the edge.
- stack_wdata = mux(push_src) in IDLE and the latched result register in WB.
  - push_src=00 with PUSH/REPLACE: writes 0, and is still a legal op.
- PUSH:
  - If not full: same cycle stack_sp=top_sp+1, stack_write=1; at the edge depth+=1.
  - If full: no write, depth unchanged, err_overflow<=1.
- POP: if depth>=1, depth-=1 with no write; else err_underflow<=1.
- REPLACE: if depth>=1, stack_sp=top_sp, stack_write=1, depth unchanged; else err_underflow<=1.
- BINOP (2 cycles):
  - Accept cycle: stack_sp=top_sp (operands on read1/read2), no write; alu_result latched at the edge; go to WB.
  - WB: op_ready=0, stack_sp=top_sp-1, stack_write=1, stack_wdata=latched value; at the edge depth-=1, return to IDLE.
  - If depth<2 at accept: no state change, err_underflow<=1, stays IDLE.
- CLEAR: depth=0, both sticky errors cleared, no write.
- NOP and illegal codes: op_done only.
- op_done: asserted the cycle after every retired op, including error-rejected ops. BINOP retires at WB exit.
- stack_write is never asserted outside a legal PUSH, REPLACE or BINOP-WB. At most one write per cycle.
- Width rules:
  - top_sp = STACK_BASE + zero-extended depth, modulo 2^32.
  - depth never wraps; overflow and underflow are blocked, not wrapped.
- An op_valid held high during WB is ignored and is accepted in the next IDLE cycle.

Decomposition:
- Package stack_ctrl_pkg holds:
  - op_code localparams (OP_NOP..OP_CLEAR);
  - push_src encodings (SRC_NONE, SRC_ALU, SRC_DMEM, SRC_PC);
  - FSM state encoding (ST_IDLE, ST_WB).
- One combinational sub-module, stack_src_mux: selects alu_result/dmem_rdata/pc_temp/0 by push_src. It is reused by the datapath.
- Depth counter and FSM stay in the top module.

Test Plan:
- After reset, PUSH src=01 alu_result=7, then PUSH src=10 dmem_rdata=4 -> stack_sp=1 then 2 with stack_write=1; depth=2, top_sp=2, read1=4, read2=7; op_done pulses twice.
- BINOP with depth=2, alu_result=11 -> accept cycle no write; next cycle op_ready=0, stack_sp=1, stack_write=1, stack_wdata=11; then depth=1, top_sp=1, op_done one cycle later.
- DEPTH=4: five PUSH src=11 pc_temp=0x40 -> four writes at SP 1..4; fifth has no write, full=1, err_overflow=1, depth=4.
- POP on empty, and BINOP with depth=1 -> no writes, depth unchanged, err_underflow=1; then CLEAR -> both errors 0, depth=0.
- REPLACE src=01 alu_result=0x55 at depth=3 -> stack_sp=3, stack_write=1, depth stays 3.
- BINOP accepted, rst_n=0 during WB -> no write that cycle; depth=0, op_ready=1, outputs at reset values.
